reg_bank: RTL

- Parametrised successor to the single load/clear register: a bank of D registers, each N bits wide.
- Each register supports per-entry operations: load, shift, rotate, increment and decrement.
- Provides two combinational read ports and a registered carry/borrow flag.
- Used as a general-purpose register file and as the working store for the lab datapath: counters, shifters and accumulators.

---
 rtl/reg_bank.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/reg_bank.sv
// ============================================================================
// reg_bank
// ----------------------------------------------------------------------------
// A bank of D general-purpose registers, each N bits wide. On each clock edge
// one entry can be loaded, shifted, rotated, incremented or decremented. The
// bank also keeps a carry flag that holds the carry, borrow or shifted-out bit
// from the most recent operation that produces one. There are two
// combinational read ports, and port A has a zero detector.
//
// Parameters
//   N   data width of each entry (N >= 2)
//   D   number of entries (D >= 1)
//   AW  address width, derived from D
//
// Ports
//   clk        in   1   clock; all state updates on posedge
//   clear      in   1   asynchronous active-high reset of all entries and carry
//   wr_en      in   1   perform op on entry wr_addr this cycle
//   wr_addr    in   AW  target entry of op (ignored when >= D)
//   op         in   3   operation code (hold/load/shl/shr/rol/ror/inc/dec)
//   wr_data    in   N   data for load
//   ser_in     in   1   serial bit shifted in by shl/shr
//   sclr       in   1   synchronous clear of entry wr_addr, qualified by wr_en
//   rd_addr_a  in   AW  read port A address
//   rd_data_a  out  N   entry rd_addr_a, or 0 when the address is >= D
//   rd_addr_b  in   AW  read port B address
//   rd_data_b  out  N   entry rd_addr_b, or 0 when the address is >= D
//   carry      out  1   carry/borrow/shifted-out bit from last such op
//   zero_a     out  1   high when rd_data_a == 0
// ============================================================================
module reg_bank #(
    parameter int N = 8,
    parameter int D = 4,
    localparam int AW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    op,
    input  logic [N-1:0]  wr_data,
    input  logic          ser_in,
    input  logic          sclr,
    input  logic [AW-1:0] rd_addr_a,
    output logic [N-1:0]  rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [N-1:0]  rd_data_b,
    output logic          carry,
    output logic          zero_a
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    // Entry count widened by one bit so that an address can be compared with
    // it. This also covers D being an exact power of two.
    localparam logic [AW:0] L_DEPTH = (AW + 1)'(D);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [N-1:0] r_mem [D];
    logic         r_carry;

    // ------------------------------------------------------------------------
    // Address qualification
    // ------------------------------------------------------------------------
    logic w_wr_valid;
    logic w_rd_a_valid;
    logic w_rd_b_valid;

    assign w_wr_valid   = ({1'b0, wr_addr}   < L_DEPTH);
    assign w_rd_a_valid = ({1'b0, rd_addr_a} < L_DEPTH);
    assign w_rd_b_valid = ({1'b0, rd_addr_b} < L_DEPTH);

    // ------------------------------------------------------------------------
    // Next value of the addressed entry and of the carry flag
    // ------------------------------------------------------------------------
    logic [N-1:0] w_cur;
    logic [N-1:0] w_next;
    logic         w_carry_next;

    always_comb begin
        // NOTE: every output of this block gets a value before the case
        // statement. Any path that leaves a signal unassigned would infer a
        // latch.
        w_cur        = w_wr_valid ? r_mem[wr_addr] : '0;
        w_next       = w_cur;
        w_carry_next = r_carry;

        if (sclr) begin
            // The entry clear takes priority over whatever op is presented.
            w_next       = '0;
            w_carry_next = 1'b0;
        end else begin
            case (op_e'(op))
                OP_HOLD: begin
                end
                OP_LOAD: begin
                    w_next = wr_data;
                end
                OP_SHL: begin
                    w_next       = {w_cur[N-2:0], ser_in};
                    w_carry_next = w_cur[N-1];
                end
                OP_SHR: begin
                    w_next       = {ser_in, w_cur[N-1:1]};
                    w_carry_next = w_cur[0];
                end
                OP_ROL: begin
                    w_next       = {w_cur[N-2:0], w_cur[N-1]};
                    w_carry_next = w_cur[N-1];
                end
                OP_ROR: begin
                    w_next       = {w_cur[0], w_cur[N-1:1]};
                    w_carry_next = w_cur[0];
                end
                OP_INC: begin
                    // The extra top bit of the sum is the carry out of the
                    // all-ones entry.
                    {w_carry_next, w_next} = {1'b0, w_cur} + (N + 1)'(1);
                end
                OP_DEC: begin
                    w_next       = w_cur - N'(1);
                    w_carry_next = (w_cur == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register update. clear is asynchronous and overrides everything. Only
    // the addressed entry is written. The carry flag updates on the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            // NOTE: the bank is built from flops, not a RAM macro, so clearing
            // every entry in the async reset branch is legal. It is also
            // required, because every entry must read 0 straight after reset.
            for (int i = 0; i < D; i++) begin
                r_mem[i] <= '0;
            end
            r_carry <= 1'b0;
        end else if (wr_en && w_wr_valid) begin
            // NOTE: state is updated only with non-blocking assignments, so
            // every entry samples pre-edge values no matter how the
            // statements are ordered.
            r_mem[wr_addr] <= w_next;
            r_carry        <= w_carry_next;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: combinational from stored state, with no write bypass
    // ------------------------------------------------------------------------
    assign rd_data_a = w_rd_a_valid ? r_mem[rd_addr_a] : '0;
    assign rd_data_b = w_rd_b_valid ? r_mem[rd_addr_b] : '0;
    assign zero_a    = (rd_data_a == '0);
    assign carry     = r_carry;

endmodule
